// File: rtl/alloc_pkg.sv
// Shared allocator/release-timer definitions: sizes, index/latency types and the latency load helper.
package alloc_pkg;

  localparam int NUM_RESOURCES = 16;
  localparam int NUM_ISSUE     = 3;
  localparam int LAT_W         = 4;
  localparam int IDX_W         = $clog2(NUM_RESOURCES);
  localparam int OCC_W         = $clog2(NUM_RESOURCES + 1);

  typedef logic [IDX_W-1:0] res_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

  // A zero latency behaves like one cycle, so the counter loads max(L,1)-1.
  function automatic lat_t lat_load(lat_t lat);
    return (lat == '0) ? '0 : lat_t'(lat - 1'b1);
  endfunction

endpackage

// File: rtl/release_counter.sv
// Single-entry release timer: busy flag plus down-counter, clear pulses when the count hits zero.
module release_counter
  import alloc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  lat_t       load_val,
  input  logic       flush,
  output logic       clear,
  output logic       busy
);

  logic busy_d, busy_q;
  lat_t cnt_d, cnt_q;

  // NOTE: clear comes purely from flops, so no issue input can reach the allocator combinationally.
  assign clear = busy_q && (cnt_q == '0);
  assign busy  = busy_q;

  // NOTE: defaults first in always_comb; any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (flush) begin
      // A squashed entry stays busy one more cycle so its clear returns it to the pool.
      if (busy_q) cnt_d = '0;
    end else if (load) begin
      busy_d = 1'b1;
      cnt_d  = load_val;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - lat_t'(1);
    end
  end

  // NOTE: synchronous active-high reset; state flops use non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/resource_release_timer.sv
// Per-resource release timers with issue-port arbitration, flush and err reporting.
// Optional macro RESOURCE_RELEASE_TIMER_OCCUPANCY_EN enables the registered occupancy count.
module resource_release_timer
  import alloc_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_ISSUE-1:0]                issue_valid,
  input  logic [NUM_ISSUE-1:0][IDX_W-1:0]     issue_idx,
  input  logic [NUM_ISSUE-1:0][LAT_W-1:0]     issue_lat,
  input  logic                                flush,
  input  logic [NUM_RESOURCES-1:0]            flush_mask,
  output logic [NUM_RESOURCES-1:0]            clear,
  output logic [NUM_RESOURCES-1:0]            busy,
  output logic                                err,
  output logic [OCC_W-1:0]                    occupancy
);

  logic [NUM_RESOURCES-1:0]            load;
  logic [NUM_RESOURCES-1:0][LAT_W-1:0] load_val;
  logic [NUM_RESOURCES-1:0]            flush_sel;
  logic                                err_d, err_q;
  logic                                dup, squashed, blocked;

  assign flush_sel = flush ? flush_mask : '0;

  // Lower-numbered ports win index collisions; flushed targets drop the issue without err.
  always_comb begin
    load     = '0;
    load_val = '0;
    err_d    = 1'b0;
    dup      = 1'b0;
    squashed = 1'b0;
    blocked  = 1'b0;
    for (int p = 0; p < NUM_ISSUE; p++) begin
      dup = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (issue_valid[q] && (issue_idx[q] == issue_idx[p])) dup = 1'b1;
      end
      squashed = flush_sel[issue_idx[p]];
      blocked  = busy[issue_idx[p]] && !clear[issue_idx[p]];
      if (issue_valid[p] && !squashed) begin
        if (dup || blocked) begin
          err_d = 1'b1;
        end else begin
          load[issue_idx[p]]     = 1'b1;
          load_val[issue_idx[p]] = lat_load(issue_lat[p]);
        end
      end
    end
  end

  for (genvar e = 0; e < NUM_RESOURCES; e++) begin : g_entry
    release_counter u_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (load[e]),
      .load_val (load_val[e]),
      .flush    (flush_sel[e]),
      .clear    (clear[e]),
      .busy     (busy[e])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;

`ifdef RESOURCE_RELEASE_TIMER_OCCUPANCY_EN
  logic [NUM_RESOURCES-1:0] busy_next;
  logic [OCC_W-1:0]         occupancy_d, occupancy_q;

  // Counting the next-state busy vector makes the registered count line up with busy.
  assign busy_next = (busy & ~clear) | load | (busy & flush_sel);

  always_comb begin
    occupancy_d = '0;
    for (int e = 0; e < NUM_RESOURCES; e++) begin
      occupancy_d = occupancy_d + OCC_W'(busy_next[e]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) occupancy_q <= '0;
    else       occupancy_q <= occupancy_d;
  end

  assign occupancy = occupancy_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_resource_release_timer.sv
// Self-checking bench: directed scenarios then random traffic, checked against a deadline-based model.
module tb_resource_release_timer;

  localparam int NR = 16;
  localparam int NI = 3;

  logic                  clock;
  logic                  reset;
  logic [NI-1:0]         issue_valid;
  logic [NI-1:0][3:0]    issue_idx;
  logic [NI-1:0][3:0]    issue_lat;
  logic                  flush;
  logic [NR-1:0]         flush_mask;
  logic [NR-1:0]         clear;
  logic [NR-1:0]         busy;
  logic                  err;
  logic [4:0]            occupancy;

  resource_release_timer dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .flush_mask  (flush_mask),
    .clear       (clear),
    .busy        (busy),
    .err         (err),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: each active entry remembers the absolute cycle in which it releases.
  int   cyc;
  bit   act [NR];
  int   rel [NR];
  logic err_exp;
  int   checks;
  int   errors;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = '0;
    issue_idx   = '0;
    issue_lat   = '0;
    flush       = 1'b0;
    flush_mask  = '0;
  endtask

  task automatic set_issue(int p, int idx, int lat);
    issue_valid[p] = 1'b1;
    issue_idx[p]   = 4'(idx);
    issue_lat[p]   = 4'(lat);
  endtask

  task automatic model_edge();
    bit claimed [NR];
    bit grant   [NR];
    int new_rel [NR];
    bit e_err;
    if (reset) begin
      foreach (act[e]) act[e] = 1'b0;
      err_exp = 1'b0;
      return;
    end
    e_err = 1'b0;
    foreach (act[e]) begin
      claimed[e] = 1'b0;
      grant[e]   = 1'b0;
      new_rel[e] = 0;
    end
    for (int p = 0; p < NI; p++) begin
      int i;
      int l;
      i = int'(issue_idx[p]);
      l = int'(issue_lat[p]);
      if (!issue_valid[p]) continue;
      if (flush && flush_mask[i]) continue;
      if (claimed[i]) begin
        e_err = 1'b1;
        continue;
      end
      claimed[i] = 1'b1;
      if (act[i] && rel[i] != cyc) begin
        e_err = 1'b1;
      end else begin
        grant[i]   = 1'b1;
        new_rel[i] = cyc + ((l == 0) ? 1 : l);
      end
    end
    foreach (act[e]) begin
      if (flush && flush_mask[e] && act[e]) begin
        rel[e] = cyc + 1;
      end else if (grant[e]) begin
        act[e] = 1'b1;
        rel[e] = new_rel[e];
      end else if (act[e] && rel[e] == cyc) begin
        act[e] = 1'b0;
      end
    end
    err_exp = e_err;
  endtask

  task automatic compare();
    logic [NR-1:0] exp_clr;
    logic [NR-1:0] exp_busy;
    int occ;
    occ = 0;
    foreach (act[e]) begin
      exp_busy[e] = act[e];
      exp_clr[e]  = act[e] && (rel[e] == cyc);
      occ += act[e] ? 1 : 0;
    end
    check("clear", 32'(clear), 32'(exp_clr));
    check("busy", 32'(busy), 32'(exp_busy));
    check("err", 32'(err), 32'(err_exp));
`ifdef RESOURCE_RELEASE_TIMER_OCCUPANCY_EN
    check("occupancy", 32'(occupancy), 32'(occ));
`else
    check("occupancy", 32'(occupancy), 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
    compare();
  endtask

  task automatic drain(int n);
    idle_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    err_exp = 1'b0;
    foreach (act[e]) begin
      act[e] = 1'b0;
      rel[e] = 0;
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_clear", 32'(clear), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_occupancy", 32'(occupancy), 32'd0);

    // Single-cycle op.
    set_issue(0, 3, 1);
    tick();
    drain(3);

    // Two ops in one cycle, one with zero latency.
    set_issue(0, 5, 4);
    set_issue(1, 6, 0);
    tick();
    drain(6);

    // Same-cycle re-issue while clear is pulsing.
    set_issue(0, 2, 3);
    tick();
    drain(2);
    set_issue(0, 2, 2);
    tick();
    drain(4);

    // Issue to a still-counting entry.
    set_issue(0, 7, 5);
    tick();
    drain(1);
    set_issue(1, 7, 3);
    tick();
    drain(6);

    // Two ports colliding on one index.
    set_issue(0, 1, 2);
    set_issue(2, 1, 6);
    tick();
    drain(8);

    // Flush mid-count.
    set_issue(0, 4, 9);
    tick();
    drain(2);
    flush      = 1'b1;
    flush_mask = 16'h0010;
    tick();
    drain(10);

    // Flush racing an issue to the same entry, plus a flush of an idle entry.
    set_issue(0, 9, 3);
    flush      = 1'b1;
    flush_mask = 16'h0200;
    tick();
    drain(4);

    // Reset mid-count discards the entry silently.
    set_issue(0, 8, 6);
    tick();
    drain(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_clear", 32'(clear), 32'd0);
    drain(8);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      for (int p = 0; p < NI; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_issue(p, int'($urandom_range(0, NR - 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(0, 4)));
        end
      end
      if ($urandom_range(0, 11) == 0) begin
        flush      = 1'b1;
        flush_mask = 16'($urandom());
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    drain(18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
